// File: rtl/bolme_birimi_pkg.sv
// Shared definitions for the RV32M divider (bolme_birimi).
// Holds the divider operation codes driven on kontrol_i and small helpers
// that decode them. Imported by bolme_birimi and its testbench.
package bolme_birimi_pkg;

  // Operation codes, same numbering as the controller's divider ops.
  localparam logic [1:0] BOLME_DIV  = 2'b00;
  localparam logic [1:0] BOLME_DIVU = 2'b01;
  localparam logic [1:0] BOLME_REM  = 2'b10;
  localparam logic [1:0] BOLME_REMU = 2'b11;

  // DIV and REM treat operands as two's complement.
  function automatic logic isaretli_islem(input logic [1:0] islem);
    return !islem[0];
  endfunction

  // REM and REMU return the remainder; DIV and DIVU return the quotient.
  function automatic logic kalan_islemi(input logic [1:0] islem);
    return islem[1];
  endfunction

endpackage

// File: rtl/bolme_adimi.sv
// One combinational restoring-division step.
// Shifts {kalan, bolum} left by one, trial-subtracts the divisor from the
// widened remainder and keeps the difference when it is non-negative,
// setting the new quotient LSB accordingly.
// Ports:
//   kalan          partial remainder (always < bolen between steps)
//   bolum          partial quotient / remaining dividend bits
//   bolen          divisor magnitude
//   kalan_sonraki  remainder after this step
//   bolum_sonraki  quotient after this step
module bolme_adimi #(
  parameter int VERI_GENISLIGI = 32
) (
  input  logic [VERI_GENISLIGI-1:0] kalan,
  input  logic [VERI_GENISLIGI-1:0] bolum,
  input  logic [VERI_GENISLIGI-1:0] bolen,
  output logic [VERI_GENISLIGI-1:0] kalan_sonraki,
  output logic [VERI_GENISLIGI-1:0] bolum_sonraki
);

  logic [VERI_GENISLIGI:0] kaydirilmis;
  logic [VERI_GENISLIGI:0] fark;

  // Because kalan < bolen, the shifted value is < 2*bolen, so the difference
  // always fits a signed VERI_GENISLIGI+1-bit value and its MSB is the sign.
  assign kaydirilmis = {kalan, bolum[VERI_GENISLIGI-1]};
  assign fark        = kaydirilmis - {1'b0, bolen};

  always_comb begin
    kalan_sonraki = kaydirilmis[VERI_GENISLIGI-1:0];
    bolum_sonraki = {bolum[VERI_GENISLIGI-2:0], 1'b0};
    if (!fark[VERI_GENISLIGI]) begin
      kalan_sonraki = fark[VERI_GENISLIGI-1:0];
      bolum_sonraki = {bolum[VERI_GENISLIGI-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/bolme_birimi.sv
// Iterative RV32M divider (DIV, DIVU, REM, REMU) for the execute stage.
// Restoring algorithm, one bit per cycle: accept, VERI_GENISLIGI steps,
// then one sign-fixup cycle that registers the result (latency 33 at 32 bits).
// Optional feature: define BOLME_ERKEN_CIKIS_EN to detect divide-by-zero
// and signed overflow at accept and skip the iteration (latency 1).
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset, wins over durdur_i
//   durdur_i   pipeline stall, freezes every register
//   basla_i    start request, accepted only when idle and not stalled
//   kontrol_i  operation code (BOLME_DIV/DIVU/REM/REMU)
//   deger1_i   dividend (rs1)
//   deger2_i   divisor (rs2)
//   sonuc_o    registered result, held until the next result
//   gecerli_o  result valid pulse, stretched while stalled
//   mesgul_o   high from accept until the cycle gecerli_o rises
module bolme_birimi
  import bolme_birimi_pkg::*;
#(
  parameter int VERI_GENISLIGI = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      durdur_i,
  input  logic                      basla_i,
  input  logic [1:0]                kontrol_i,
  input  logic [VERI_GENISLIGI-1:0] deger1_i,
  input  logic [VERI_GENISLIGI-1:0] deger2_i,
  output logic [VERI_GENISLIGI-1:0] sonuc_o,
  output logic                      gecerli_o,
  output logic                      mesgul_o
);

  localparam int W  = VERI_GENISLIGI;
  localparam int SW = $clog2(W);
  localparam logic [W-1:0] EN_KUCUK = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {BOSTA, HESAPLA, DUZELT} durum_e;

  durum_e        durum;
  logic [SW-1:0] sayac;
  logic [1:0]    islem;
  logic [W-1:0]  kalan, bolum, bolen, bolunen;
  logic          isaret_q, isaret_r, sifir_bolen, tasma;

  // Operand decode at accept time.
  logic         isaretli;
  logic [W-1:0] mutlak1, mutlak2;
  logic         giris_sifir, giris_tasma;

  assign isaretli    = isaretli_islem(kontrol_i);
  // -0x80000000 wraps back to itself, which is the correct unsigned magnitude.
  assign mutlak1     = (isaretli && deger1_i[W-1]) ? -deger1_i : deger1_i;
  assign mutlak2     = (isaretli && deger2_i[W-1]) ? -deger2_i : deger2_i;
  assign giris_sifir = (deger2_i == '0);
  assign giris_tasma = isaretli && (deger1_i == EN_KUCUK) && (deger2_i == '1);

  logic [W-1:0] kalan_s, bolum_s;

  bolme_adimi #(.VERI_GENISLIGI(W)) u_adim (
    .kalan         (kalan),
    .bolum         (bolum),
    .bolen         (bolen),
    .kalan_sonraki (kalan_s),
    .bolum_sonraki (bolum_s)
  );

  // Sign fixup and special-case override, registered in DUZELT.
  logic [W-1:0] q_son, r_son, sonuc_sonraki;
  assign q_son = isaret_q ? -bolum : bolum;
  assign r_son = isaret_r ? -kalan : kalan;

  always_comb begin
    sonuc_sonraki = kalan_islemi(islem) ? r_son : q_son;
    if (sifir_bolen)
      sonuc_sonraki = kalan_islemi(islem) ? bolunen : '1;
    else if (tasma)
      sonuc_sonraki = kalan_islemi(islem) ? '0 : EN_KUCUK;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum       <= BOSTA;
      sayac       <= '0;
      islem       <= BOLME_DIV;
      kalan       <= '0;
      bolum       <= '0;
      bolen       <= '0;
      bolunen     <= '0;
      isaret_q    <= 1'b0;
      isaret_r    <= 1'b0;
      sifir_bolen <= 1'b0;
      tasma       <= 1'b0;
      sonuc_o     <= '0;
      gecerli_o   <= 1'b0;
      mesgul_o    <= 1'b0;
    end else if (!durdur_i) begin
      case (durum)
        BOSTA: begin
          // A held-over valid clears on the first unstalled edge.
          gecerli_o <= 1'b0;
          if (basla_i) begin
            islem       <= kontrol_i;
            kalan       <= '0;
            bolum       <= mutlak1;
            bolen       <= mutlak2;
            bolunen     <= deger1_i;
            isaret_q    <= isaretli && (deger1_i[W-1] ^ deger2_i[W-1]);
            isaret_r    <= isaretli && deger1_i[W-1];
            sifir_bolen <= giris_sifir;
            tasma       <= giris_tasma;
            sayac       <= '0;
            mesgul_o    <= 1'b1;
`ifdef BOLME_ERKEN_CIKIS_EN
            durum       <= (giris_sifir || giris_tasma) ? DUZELT : HESAPLA;
`else
            durum       <= HESAPLA;
`endif
          end
        end
        HESAPLA: begin
          kalan <= kalan_s;
          bolum <= bolum_s;
          sayac <= sayac + 1'b1;
          if (sayac == SW'(W - 1))
            durum <= DUZELT;
        end
        DUZELT: begin
          sonuc_o   <= sonuc_sonraki;
          gecerli_o <= 1'b1;
          mesgul_o  <= 1'b0;
          durum     <= BOSTA;
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_bolme_birimi.sv
// Self-checking bench for bolme_birimi: directed RV32M cases, randomized
// operations against an arithmetic reference model, stall/back-to-back and
// mid-operation reset scenarios.
module tb_bolme_birimi
  import bolme_birimi_pkg::*;
;

  logic        clk = 1'b0;
  logic        rst, durdur, basla;
  logic [1:0]  kontrol;
  logic [31:0] deger1, deger2;
  logic [31:0] sonuc;
  logic        gecerli, mesgul;

  int checks   = 0;
  int failures = 0;

  bolme_birimi #(.VERI_GENISLIGI(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .durdur_i  (durdur),
    .basla_i   (basla),
    .kontrol_i (kontrol),
    .deger1_i  (deger1),
    .deger2_i  (deger2),
    .sonuc_o   (sonuc),
    .gecerli_o (gecerli),
    .mesgul_o  (mesgul)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M-extension semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      BOLME_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb;
      end
      BOLME_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = longint'(a) / longint'(b);
      end
      BOLME_REM:  begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb;
      end
      default:    begin
        if (b == 0) return a;
        r = longint'(a) % longint'(b);
      end
    endcase
    return r[31:0];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef BOLME_ERKEN_CIKIS_EN
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation and waits (bounded) for gecerli; reports result,
  // cycles from accept, and whether mesgul stayed high while waiting.
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    kontrol = op; deger1 = a; deger2 = b; basla = 1'b1;
    step();
    basla = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!gecerli && lat < 100) begin
      if (!mesgul) busy_ok = 1'b0;
      step();
      lat++;
    end
    res = sonuc;
  endtask

  task automatic test_reset();
    rst = 1'b1; durdur = 1'b0; basla = 1'b0; kontrol = BOLME_DIV; deger1 = '0; deger2 = '0;
    step(); step();
    checks++;
    if (sonuc !== 32'h0 || gecerli !== 1'b0 || mesgul !== 1'b0) begin
      failures++;
      $display("FAIL reset: sonuc=%h gecerli=%b mesgul=%b, want 0/0/0", sonuc, gecerli, mesgul);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [1:0]  ops [9] = '{BOLME_DIV, BOLME_REM, BOLME_DIV, BOLME_DIVU, BOLME_REMU,
                             BOLME_DIV, BOLME_REMU, BOLME_DIV, BOLME_REM};
    logic [31:0] as  [9] = '{32'd100, -32'sd100, -32'sd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [9] = '{32'd7, 32'd7, 32'd7, 32'd2, 32'd16,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [9] = '{32'd14, -32'sd2, -32'sd14, 32'h7FFF_FFFF, 32'hF,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    logic [31:0] res;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 9; i++) begin
      do_div(ops[i], as[i], bs[i], res, lat, busy_ok);
      checks++;
      if (res !== ex[i]) begin
        failures++;
        $display("FAIL directed[%0d] result: got %h want %h", i, res, ex[i]);
      end
      checks++;
      if (lat != exp_lat(ops[i], as[i], bs[i]) || !busy_ok || mesgul !== 1'b0) begin
        failures++;
        $display("FAIL directed[%0d] timing: lat=%0d want %0d busy_ok=%b mesgul=%b",
                 i, lat, exp_lat(ops[i], as[i], bs[i]), busy_ok, mesgul);
      end
      step();
      checks++;
      if (gecerli !== 1'b0) begin
        failures++;
        $display("FAIL directed[%0d] pulse: gecerli=%b one cycle later, want 0", i, gecerli);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b;
    logic [1:0]  op;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = a >> $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      // Back-to-back: each start lands in the previous result's valid cycle.
      do_div(op, a, b, res, lat, busy_ok);
      checks++;
      if (res !== model(op, a, b) || lat != exp_lat(op, a, b) || !busy_ok) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat=%0d busy_ok=%b want %h lat=%0d",
                 i, op, a, b, res, lat, busy_ok, model(op, a, b), exp_lat(op, a, b));
      end
    end
    step();
  endtask

  task automatic test_stall_back_to_back();
    int lat, vcnt;
    bit busy_ok;
    logic [31:0] a2, b2;
    kontrol = BOLME_DIVU; deger1 = 32'd1000; deger2 = 32'd10; basla = 1'b1;
    step();
    basla = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!gecerli && lat < 100) begin
      if (!mesgul) busy_ok = 1'b0;
      durdur = (lat >= 10 && lat < 15);
      step();
      lat++;
    end
    durdur = 1'b0;
    checks++;
    if (lat != 38 || sonuc !== 32'd100 || !busy_ok) begin
      failures++;
      $display("FAIL stall latency: lat=%0d sonuc=%0d busy_ok=%b, want 38/100/1", lat, sonuc, busy_ok);
    end
    vcnt = gecerli ? 1 : 0;
    durdur = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      if (gecerli) vcnt++;
    end
    checks++;
    if (sonuc !== 32'd100 || mesgul !== 1'b0) begin
      failures++;
      $display("FAIL stall hold: sonuc=%0d mesgul=%b, want 100/0", sonuc, mesgul);
    end
    // Final valid cycle: release the stall and start the next division.
    a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
    durdur = 1'b0; kontrol = BOLME_DIV; deger1 = a2; deger2 = b2; basla = 1'b1;
    step();
    basla = 1'b0;
    checks++;
    if (vcnt != 3 || gecerli !== 1'b0 || mesgul !== 1'b1) begin
      failures++;
      $display("FAIL stall valid: valid_cycles=%0d gecerli=%b mesgul=%b, want 3/0/1", vcnt, gecerli, mesgul);
    end
    lat = 0;
    while (!gecerli && lat < 100) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 33 || sonuc !== model(BOLME_DIV, a2, b2)) begin
      failures++;
      $display("FAIL back_to_back: lat=%0d sonuc=%h, want 33/%h", lat, sonuc, model(BOLME_DIV, a2, b2));
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    bit busy_ok, seen;
    kontrol = BOLME_DIVU; deger1 = 32'd77777; deger2 = 32'd13; basla = 1'b1;
    step();
    basla = 1'b0;
    for (int k = 0; k < 9; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (sonuc !== 32'h0 || gecerli !== 1'b0 || mesgul !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: sonuc=%h gecerli=%b mesgul=%b, want 0/0/0", sonuc, gecerli, mesgul);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (gecerli || mesgul) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid abort: gecerli/mesgul seen after reset, want none");
    end
    do_div(BOLME_DIV, 32'd9, 32'd3, res, lat, busy_ok);
    checks++;
    if (res !== 32'd3 || lat != 33 || !busy_ok) begin
      failures++;
      $display("FAIL reset_mid restart: sonuc=%0d lat=%0d busy_ok=%b, want 3/33/1", res, lat, busy_ok);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bolme_birimi.md
# bolme_birimi

Iterative RV32M divider executing DIV, DIVU, REM and REMU in the execute stage. It sits beside carpma_birimi: same operand lines from the register-read/forwarding path, same durdur_i stall, and its result feeds the same writeback mux. It is multi-cycle, so it exposes a start/busy/valid handshake that the controller uses to hold the pipeline.

## Interface
- VERI_GENISLIGI, 32: operand/result width; iteration count equals this value.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- durdur_i  in  1  pipeline stall; freezes all internal state and outputs.
- basla_i  in  1  start request; operands and kontrol_i sampled when accepted.
- kontrol_i  in  2  operation: `BOLME_DIV, `BOLME_DIVU, `BOLME_REM, `BOLME_REMU.
- deger1_i  in  VERI_GENISLIGI  dividend (rs1).
- deger2_i  in  VERI_GENISLIGI  divisor (rs2).
- sonuc_o  out  VERI_GENISLIGI  registered result; holds until the next result.
- gecerli_o  out  1  result valid, one-cycle pulse (stretched under stall).
- mesgul_o  out  1  high from accept until the cycle gecerli_o rises.

## Operation
- FSM states: BOSTA, HESAPLA, DUZELT.
- BOSTA: basla_i=1 and durdur_i=0 accepts. Latch op; compute magnitudes for signed ops (DIV/REM); record quotient sign (sign1 XOR sign2) and remainder sign (sign1). Clear counter. Go to HESAPLA; mesgul_o=1.
- HESAPLA: one restoring step per cycle.
  - shift {remainder, quotient} left by 1;
  - trial-subtract the divisor magnitude with a VERI_GENISLIGI+1-bit subtractor;
  - if the result is non-negative, keep it and set the quotient LSB.
  - After VERI_GENISLIGI steps, go to DUZELT.
- DUZELT:
  - apply signs: negate the quotient if its sign is set; negate the remainder if dividend negative;
  - select quotient (DIV/DIVU) or remainder (REM/REMU) into sonuc_o;
  - gecerli_o=1, mesgul_o=0, go to BOSTA.
- Special cases, forced at DUZELT regardless of datapath:
  - divisor 0: DIV/DIVU give all ones; REM/REMU give the dividend unchanged.
  - signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- basla_i while mesgul_o=1 is ignored (no queueing); the controller must not assert it.
- Back-to-back: basla_i may be high in the same cycle gecerli_o is high. It is accepted, since the FSM is in BOSTA.

## Timing
- Reset values: sonuc_o=0, gecerli_o=0, mesgul_o=0, state BOSTA, counter 0.
- Accept edge = E0. HESAPLA occupies edges E1..E32. DUZELT registers the result at E33.
- gecerli_o and the new sonuc_o are visible after E33: latency 33 cycles without stall.
- durdur_i=1 freezes every register: state, counter, partials, sonuc_o, gecerli_o, mesgul_o. Each stalled cycle adds exactly one cycle of latency.
- gecerli_o=1 while durdur_i=1: gecerli_o stays high until the first non-stalled edge, then clears. The consumer never misses a result.
- basla_i with durdur_i=1 is not accepted.
- rst_i mid-operation aborts at the next edge: outputs return to reset values and no gecerli_o is produced.
- rst_i has priority over durdur_i.

## Configuration
- BOLME_ERKEN_CIKIS_EN defined: divisor-zero and signed-overflow cases are detected at accept. The FSM skips HESAPLA and goes straight to DUZELT, so the result is valid after E1 (latency 1).
- Not defined: special cases take the full 33-cycle path. Result values are identical; only latency differs.

## Structure
- `BOLME_DIV=2'b00, `BOLME_DIVU=2'b01, `BOLME_REM=2'b10, `BOLME_REMU=2'b11 belong in riscv_controller.vh, alongside the existing multiplier op codes.
- FSM state encodings stay local to the module.
- One sub-module: bolme_adimi. It is a combinational single restoring step: inputs are partial remainder, quotient and divisor; outputs are the next remainder and quotient.
- Test bench: tb_bolme_birimi.

## Test plan
- DIV 100/7 → sonuc_o=14. gecerli_o rises 33 cycles after accept; mesgul_o high throughout.
- REM -100/7 → -2; DIV -100/7 → -14; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF; REMU 0xFFFFFFFF/16 → 0xF.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - Latency 1 with BOLME_ERKEN_CIKIS_EN, 33 without.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- durdur_i high for 5 cycles mid-HESAPLA, plus 2 cycles while gecerli_o=1:
  - DIVU 1000/10 → 100 at latency 38;
  - gecerli_o high for 3 cycles;
  - a second basla_i in the final valid cycle starts the next division.
- rst_i asserted at E10 of a division → gecerli_o never pulses; sonuc_o=0, mesgul_o=0 at the next edge. A new DIV 9/3 afterwards → 3.
